// File: rtl/delay_estimator.sv
// Loop-latency probe: injects one AMPLITUDE sample and counts ce-qualified samples
// until |sig_in| crosses THRESH, or gives up after MAX_DELAY.
module delay_estimator #(
    parameter int DW        = 16,
    parameter int CW        = 8,
    parameter int AMPLITUDE = 16384,
    parameter int THRESH    = 8192,
    parameter int MAX_DELAY = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce_in,
    output logic                 ce_out,
    input  logic                 start,
    input  logic signed [DW-1:0] sig_in,
    output logic signed [DW-1:0] probe_out,
    output logic [CW-1:0]        delay_out,
    output logic                 valid,
    output logic                 busy,
    output logic                 timeout
);
    localparam logic [DW-1:0] LP_AMP    = DW'(AMPLITUDE);
    localparam logic [DW-1:0] LP_THRESH = DW'(THRESH);
    localparam logic [DW-1:0] LP_POSMAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [CW-1:0] LP_MAX    = CW'(MAX_DELAY);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PROBE, S_LISTEN} state_t;

    state_t          r_state, w_state_nxt;
    logic [DW-1:0]   r_probe, w_probe_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic [CW-1:0]   r_delay, w_delay_nxt;
    logic            r_valid, w_valid_nxt;
    logic            r_busy, w_busy_nxt;
    logic            r_timeout, w_timeout_nxt;
    logic            r_ce;

    logic [DW-1:0]   w_neg, w_mag;
    logic            w_hit, w_last, w_check;

    // Negating the most negative sample overflows back to itself; clamp it instead.
    assign w_neg   = -sig_in;
    assign w_mag   = sig_in[DW-1] ? (w_neg[DW-1] ? LP_POSMAX : w_neg) : sig_in;
    assign w_hit   = (w_mag >= LP_THRESH);
    assign w_last  = (r_count == LP_MAX);
    assign w_check = ce_in && ((r_state == S_PROBE) || (r_state == S_LISTEN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:           if (start) w_state_nxt = S_ARMED;
            S_ARMED:          if (ce_in) w_state_nxt = S_PROBE;
            S_PROBE, S_LISTEN: if (ce_in) w_state_nxt = (w_hit || w_last) ? S_IDLE : S_LISTEN;
            default:          w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_probe_nxt   = r_probe;
        w_count_nxt   = r_count;
        w_delay_nxt   = r_delay;
        w_valid_nxt   = r_valid;
        w_busy_nxt    = r_busy;
        w_timeout_nxt = 1'b0;
        if (r_state == S_IDLE && start) begin
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b1;
        end
        if (r_state == S_ARMED && ce_in) begin
            w_probe_nxt = LP_AMP;
            w_count_nxt = '0;
        end
        // The probe is a single ce sample; it is withdrawn on the first check whatever the outcome.
        if (w_check) begin
            w_probe_nxt = '0;
            if (w_hit) begin
                w_delay_nxt = r_count;
                w_valid_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end else if (w_last) begin
                w_timeout_nxt = 1'b1;
                w_busy_nxt    = 1'b0;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_probe   <= '0;
            r_count   <= '0;
            r_delay   <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
            r_ce      <= 1'b0;
        end else begin
            r_probe   <= w_probe_nxt;
            r_count   <= w_count_nxt;
            r_delay   <= w_delay_nxt;
            r_valid   <= w_valid_nxt;
            r_busy    <= w_busy_nxt;
            r_timeout <= w_timeout_nxt;
            r_ce      <= ce_in;
        end
    end

    assign probe_out = r_probe;
    assign delay_out = r_delay;
    assign valid     = r_valid;
    assign busy      = r_busy;
    assign timeout   = r_timeout;
    assign ce_out    = r_ce;
endmodule

// File: tb/tb_delay_estimator.sv
// Bench for delay_estimator: programmable ce-gated loopback path, cycle model, literal checks.
module tb_delay_estimator;
    localparam int DW = 16, CW = 8, AMP = 16384, THR = 8192, MAXD = 255;

    logic clk = 0, reset = 1, ce_in = 0, start = 0, flush = 1;
    logic signed [DW-1:0] sig_in, probe_out;
    logic ce_out, valid, busy, timeout;
    logic [CW-1:0] delay_out;

    int n_chk = 0, n_fail = 0;
    int depth = 0, pmode = 0, ce_mode = 0;
    int cyc = 0, probe_clks = 0, probe_cyc = 0, to_cnt = 0, to_cyc = 0, busy_rises = 0;
    bit prev_amp = 0, prev_busy = 0;

    always #5 clk = ~clk;

    delay_estimator #(.DW(DW), .CW(CW), .AMPLITUDE(AMP), .THRESH(THR), .MAX_DELAY(MAXD)) dut (
        .clk(clk), .reset(reset), .ce_in(ce_in), .ce_out(ce_out), .start(start),
        .sig_in(sig_in), .probe_out(probe_out), .delay_out(delay_out),
        .valid(valid), .busy(busy), .timeout(timeout)
    );

    // Path under test: ce-gated shift register of selectable depth plus a return mapping.
    logic signed [DW-1:0] pipe [0:31];
    logic signed [DW-1:0] raw;
    always @(posedge clk) begin
        if (flush) begin
            for (int i = 0; i < 32; i++) pipe[i] <= '0;
        end else if (ce_in) begin
            pipe[0] <= probe_out;
            for (int i = 1; i < 32; i++) pipe[i] <= pipe[i-1];
        end
    end
    always_comb begin
        raw = (depth == 0) ? probe_out : pipe[depth-1];
        sig_in = '0;
        case (pmode)
            0: sig_in = raw;
            1: sig_in = -raw;
            2: sig_in = (raw != 0) ? 16'sh8000 : 16'sh0000;
            3: sig_in = (raw != 0) ? 16'sd8191 : 16'sd0;
            default: sig_in = '0;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit detect(input logic signed [DW-1:0] s);
        int v;
        v = s;
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v >= THR;
    endfunction

    // Model: k = ce samples elapsed since the probe appeared; -2 idle, -1 waiting to probe.
    int m_k = -2, m_probe = 0, m_delay = 0;
    bit m_valid = 0, m_busy = 0, m_to = 0, m_ce = 0;
    always @(negedge clk) begin
        if (reset) begin
            m_k = -2; m_probe = 0; m_delay = 0;
            m_valid = 0; m_busy = 0; m_to = 0; m_ce = 0;
        end
        chk("m_ce_out", ce_out, m_ce);
        chk("m_probe_out", probe_out, m_probe);
        chk("m_delay_out", delay_out, m_delay);
        chk("m_valid", valid, m_valid);
        chk("m_busy", busy, m_busy);
        chk("m_timeout", timeout, m_to);
        cyc++;
        if (probe_out == AMP) probe_clks++;
        if (probe_out == AMP && !prev_amp) probe_cyc = cyc;
        prev_amp = (probe_out == AMP);
        if (timeout) begin to_cnt++; to_cyc = cyc; end
        if (busy && !prev_busy) busy_rises++;
        prev_busy = busy;
        if (!reset) begin
            m_ce = ce_in;
            m_to = 0;
            if (m_k == -2) begin
                if (start) begin m_k = -1; m_valid = 0; m_busy = 1; end
            end else if (ce_in) begin
                if (m_k == -1) begin
                    m_probe = AMP; m_k = 0;
                end else begin
                    m_probe = 0;
                    if (detect(sig_in)) begin
                        m_delay = m_k; m_valid = 1; m_busy = 0; m_k = -2;
                    end else if (m_k == MAXD) begin
                        m_to = 1; m_busy = 0; m_k = -2;
                    end else m_k++;
                end
            end
        end
    end

    int ph = 0;
    initial forever begin
        @(posedge clk); #1;
        case (ce_mode)
            0: ce_in = 1;
            1: begin ce_in = (ph == 0); ph = (ph + 1) % 3; end
            default: ce_in = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 5000) begin tick(); n++; end
        if (busy) begin n_chk++; n_fail++; $display("FAIL %s_busy_bound: busy still %0d expected 0", nm, busy); end
        repeat (2) tick();
    endtask

    task automatic measure(input int d, input int m, input string nm);
        flush = 1; tick(); tick(); flush = 0;
        depth = d; pmode = m;
        tick(); start = 1; tick(); start = 0;
        wait_idle(nm);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        chk("rst_delay", delay_out, 0); chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0); chk("rst_probe", probe_out, 0);
        reset = 0; flush = 0;
        tick();

        probe_clks = 0;
        measure(8, 0, "t1");
        chk("t1_delay", delay_out, 8); chk("t1_valid", valid, 1);
        chk("t1_busy", busy, 0); chk("t1_probe_clks", probe_clks, 1);

        to_cnt = 0;
        measure(1, 4, "t3");
        chk("t3_pulses", to_cnt, 1); chk("t3_latency", to_cyc - probe_cyc, 256);
        chk("t3_delay_kept", delay_out, 8); chk("t3_valid", valid, 0);

        measure(0, 0, "t2");
        chk("t2_delay", delay_out, 0); chk("t2_valid", valid, 1);

        ce_mode = 1; probe_clks = 0;
        measure(5, 0, "t4");
        chk("t4_delay", delay_out, 5); chk("t4_probe_clks", probe_clks, 3);
        ce_mode = 0;

        measure(3, 1, "t5_inv");
        chk("t5_inv_delay", delay_out, 3);
        measure(4, 2, "t5_min");
        chk("t5_min_delay", delay_out, 4); chk("t5_min_valid", valid, 1);
        to_cnt = 0;
        measure(2, 3, "t5_8191");
        chk("t5_8191_timeout", to_cnt, 1); chk("t5_8191_valid", valid, 0);
        chk("t5_8191_delay", delay_out, 4);

        flush = 1; tick(); tick(); flush = 0;
        depth = 12; pmode = 0; busy_rises = 0;
        tick(); start = 1; tick(); start = 0;
        repeat (4) tick(); start = 1; tick(); start = 0;
        wait_idle("t6_dbl");
        repeat (30) tick();
        chk("t6_busy_rises", busy_rises, 1); chk("t6_delay", delay_out, 12);
        chk("t6_valid", valid, 1);

        flush = 1; tick(); tick(); flush = 0;
        depth = 20;
        tick(); start = 1; tick(); start = 0;
        repeat (8) tick();
        chk("t6_busy_before_rst", busy, 1);
        reset = 1; #1;
        chk("t6_rst_busy", busy, 0); chk("t6_rst_valid", valid, 0);
        chk("t6_rst_delay", delay_out, 0); chk("t6_rst_probe", probe_out, 0);
        chk("t6_rst_ce_out", ce_out, 0); chk("t6_rst_timeout", timeout, 0);
        tick(); tick(); reset = 0;
        measure(6, 0, "t6_after");
        chk("t6_after_delay", delay_out, 6); chk("t6_after_valid", valid, 1);

        ce_mode = 2;
        for (int it = 0; it < 8; it++) begin
            int d, m;
            d = $urandom_range(0, 20);
            m = $urandom_range(0, 2);
            measure(d, m, "rnd");
            chk("rnd_delay", delay_out, d); chk("rnd_valid", valid, 1);
        end
        ce_mode = 0;
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
